// File: rtl/fft_pkg.sv
// Shared FFT front-end constants, lane packing layout and input-buffer state type.
package fft_pkg;

    localparam int unsigned FFT_N      = 256;
    localparam int unsigned LANES      = 8;
    localparam int unsigned BEATS      = 32;
    localparam int unsigned IN_W       = 16;
    localparam int unsigned LANE_W     = 28;
    localparam int unsigned CPLX_W     = 2 * LANE_W;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned BEAT_W     = 5;
    localparam int unsigned LANE_IDX_W = 3;

    // Packed-lane field positions: real in the low half, imag in the high half.
    localparam int unsigned RE_LSB = 0;
    localparam int unsigned RE_MSB = LANE_W - 1;
    localparam int unsigned IM_LSB = LANE_W;
    localparam int unsigned IM_MSB = CPLX_W - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        UNLOAD = 2'd2
    } state_t;

    typedef struct packed {
        logic [IN_W-1:0] im;
        logic [IN_W-1:0] re;
    } sample_t;

    typedef struct packed {
        logic [LANE_W-1:0] im;
        logic [LANE_W-1:0] re;
    } lane_t;

    // Sign-extend both halves of a stored sample into the downstream lane format.
    function automatic lane_t pack_lane(input sample_t s);
        lane_t l;
        l.re = {{(LANE_W-IN_W){s.re[IN_W-1]}}, s.re};
        l.im = {{(LANE_W-IN_W){s.im[IN_W-1]}}, s.im};
        return l;
    endfunction

endpackage

// File: rtl/bit_reverse.sv
// Combinational 8-bit address bit reversal for the bit-reversed read order.
module bit_reverse
    import fft_pkg::*;
(
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout
);

    for (genvar i = 0; i < ADDR_W; i++) begin : g_bit
        assign dout[i] = din[ADDR_W-1-i];
    end

endmodule

// File: rtl/input_buffer.sv
// Collects a 256-sample complex frame, then unloads it as 32 beats of 8 packed lanes.
// Define INPUT_BUFFER_BITREV_EN to read the frame in bit-reversed address order.
module input_buffer
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              startin,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   realin,
    input  logic [IN_W-1:0]   imagin,
    output logic              ready,
    output logic [CPLX_W-1:0] out0,
    output logic [CPLX_W-1:0] out1,
    output logic [CPLX_W-1:0] out2,
    output logic [CPLX_W-1:0] out3,
    output logic [CPLX_W-1:0] out4,
    output logic [CPLX_W-1:0] out5,
    output logic [CPLX_W-1:0] out6,
    output logic [CPLX_W-1:0] out7,
    output logic [BEAT_W-1:0] cal_cycles,
    output logic              data_valid,
    output logic              start_calc
);

    state_t              state;
    logic [ADDR_W-1:0]   wr_cnt;
    logic [BEAT_W-1:0]   beat;
    sample_t             mem [FFT_N];
    lane_t               lane_q [LANES];
    logic [ADDR_W-1:0]   rd_addr [LANES];

    logic                accept_c;
    logic                write_en_c;
    logic [ADDR_W-1:0]   wr_addr_c;

    // A startin sample always lands at index 0; IDLE samples without startin are dropped.
    assign accept_c   = in_valid && ready;
    assign write_en_c = accept_c && ((state == LOAD) || startin);
    assign wr_addr_c  = startin ? '0 : wr_cnt;

    always_ff @(posedge clk) begin
        if (write_en_c && !reset) begin
            mem[wr_addr_c] <= '{im: imagin, re: realin};
        end
    end

    // Lane k of beat b reads address {b, k}, optionally bit-reversed.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [LANE_IDX_W-1:0] LANE_IDX = LANE_IDX_W'(k);
        logic [ADDR_W-1:0] nat_addr;
        assign nat_addr = {beat, LANE_IDX};
`ifdef INPUT_BUFFER_BITREV_EN
        bit_reverse u_bitrev (
            .din  (nat_addr),
            .dout (rd_addr[k])
        );
`else
        assign rd_addr[k] = nat_addr;
`endif
    end

    // Frame control; ready tracks the next state so it is low exactly while in UNLOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            beat       <= '0;
            ready      <= 1'b1;
            data_valid <= 1'b0;
            start_calc <= 1'b0;
            cal_cycles <= '0;
            for (int k = 0; k < LANES; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            data_valid <= 1'b0;
            start_calc <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c && startin) begin
                        wr_cnt <= ADDR_W'(1);
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept_c) begin
                        if (startin) begin
                            wr_cnt <= ADDR_W'(1);
                        end else if (wr_cnt == ADDR_W'(FFT_N - 1)) begin
                            wr_cnt <= '0;
                            beat   <= '0;
                            ready  <= 1'b0;
                            state  <= UNLOAD;
                        end else begin
                            wr_cnt <= ADDR_W'(wr_cnt + ADDR_W'(1));
                        end
                    end
                end
                UNLOAD: begin
                    data_valid <= 1'b1;
                    start_calc <= (beat == '0);
                    cal_cycles <= beat;
                    for (int k = 0; k < LANES; k++) begin
                        lane_q[k] <= pack_lane(mem[rd_addr[k]]);
                    end
                    if (beat == BEAT_W'(BEATS - 1)) begin
                        beat  <= '0;
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        beat <= BEAT_W'(beat + BEAT_W'(1));
                    end
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign out0 = lane_q[0];
    assign out1 = lane_q[1];
    assign out2 = lane_q[2];
    assign out3 = lane_q[3];
    assign out4 = lane_q[4];
    assign out5 = lane_q[5];
    assign out6 = lane_q[6];
    assign out7 = lane_q[7];

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer: frame load/unload, gaps, restart, reset and back-to-back frames.
module tb_input_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startin = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] realin = '0;
    logic [15:0] imagin = '0;
    logic        ready;
    logic [55:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [4:0]  cal_cycles;
    logic        data_valid;
    logic        start_calc;

    input_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .startin    (startin),
        .in_valid   (in_valid),
        .realin     (realin),
        .imagin     (imagin),
        .ready      (ready),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out4       (out4),
        .out5       (out5),
        .out6       (out6),
        .out7       (out7),
        .cal_cycles (cal_cycles),
        .data_valid (data_valid),
        .start_calc (start_calc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int first_dv_cyc = 0;
    int exp_re [256];
    int exp_im [256];
    logic [55:0] outs [8];
    logic [55:0] snap0 [8];
    logic [55:0] snap5 [8];
    logic [55:0] snap31 [8];

    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;
    assign outs[4] = out4;
    assign outs[5] = out5;
    assign outs[6] = out6;
    assign outs[7] = out7;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_idx(input int b, input int k);
        int i;
        logic [7:0] a;
        logic [7:0] r;
        i = 8 * b + k;
        a = i[7:0];
        r = a;
`ifdef INPUT_BUFFER_BITREV_EN
        for (int j = 0; j < 8; j++) r[j] = a[7-j];
`endif
        return int'(r);
    endfunction

    function automatic logic [55:0] exp_lane(input int i);
        logic [27:0] r;
        logic [27:0] m;
        r = 28'(exp_re[i]);
        m = 28'(exp_im[i]);
        return {m, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input int re, input int im, input bit st);
        realin   = 16'(re);
        imagin   = 16'(im);
        startin  = st;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        startin  = 1'b0;
    endtask

    // mode 0: re = i, im = -i; mode 1: every sample 7 + j7.
    task automatic send_frame(input int mode, input bit gapped);
        int re;
        int im;
        for (int i = 0; i < 256; i++) begin
            re = (mode == 0) ? i : 7;
            im = (mode == 0) ? -i : 7;
            exp_re[i] = re;
            exp_im[i] = im;
            drive_sample(re, im, i == 0);
            if (gapped && i != 255) tick();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL %s data_valid got %b want 0", name, data_valid); end
        checks++;
        if (start_calc !== 1'b0) begin errors++; $display("FAIL %s start_calc got %b want 0", name, start_calc); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL %s ready got %b want 1", name, ready); end
        checks++;
        if (cal_cycles !== 5'd0) begin errors++; $display("FAIL %s cal_cycles got %0d want 0", name, cal_cycles); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (outs[k] !== 56'd0) begin errors++; $display("FAIL %s out%0d got %h want 0", name, k, outs[k]); end
        end
    endtask

    // Waits for the unload to start and checks every beat against the bench's sample model.
    task automatic collect(input string name, input int exp_ticks, input bit leave_at_last);
        int n;
        n = 0;
        while (data_valid !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        checks++;
        if (data_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s data_valid timeout after %0d cycles want within 600", name, n);
            return;
        end
        checks++;
        if (n != exp_ticks) begin errors++; $display("FAIL %s latency got %0d want %0d", name, n, exp_ticks); end
        first_dv_cyc = cyc;
        for (int b = 0; b < 32; b++) begin
            checks++;
            if (data_valid !== 1'b1) begin errors++; $display("FAIL %s beat %0d data_valid got %b want 1", name, b, data_valid); end
            checks++;
            if (cal_cycles !== 5'(b)) begin errors++; $display("FAIL %s beat %0d cal_cycles got %0d want %0d", name, b, cal_cycles, b); end
            checks++;
            if (start_calc !== (b == 0)) begin errors++; $display("FAIL %s beat %0d start_calc got %b want %b", name, b, start_calc, b == 0); end
            checks++;
            if (ready !== (b == 31)) begin errors++; $display("FAIL %s beat %0d ready got %b want %b", name, b, ready, b == 31); end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (outs[k] !== exp_lane(exp_idx(b, k))) begin
                    errors++;
                    $display("FAIL %s beat %0d out%0d got %h want %h", name, b, k, outs[k], exp_lane(exp_idx(b, k)));
                end
                if (b == 0) snap0[k] = outs[k];
                if (b == 5) snap5[k] = outs[k];
                if (b == 31) snap31[k] = outs[k];
            end
            if (b < 31) tick();
        end
        if (!leave_at_last) begin
            tick();
            checks++;
            if (data_valid !== 1'b0) begin errors++; $display("FAIL %s post data_valid got %b want 0", name, data_valid); end
            checks++;
            if (cal_cycles !== 5'd31) begin errors++; $display("FAIL %s hold cal_cycles got %0d want 31", name, cal_cycles); end
            checks++;
            if (out7 !== exp_lane(exp_idx(31, 7))) begin errors++; $display("FAIL %s hold out7 got %h want %h", name, out7, exp_lane(exp_idx(31, 7))); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_outputs("reset");
        // Samples without startin in IDLE are discarded.
        drive_sample(11, 22, 1'b0);
        drive_sample(33, 44, 1'b0);
        repeat (3) tick();
        checks++;
        if (ready !== 1'b1 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_discard ready/data_valid got %b/%b want 1/0", ready, data_valid);
        end
    endtask

    task automatic test_natural();
        send_frame(0, 1'b0);
        collect("natural", 1, 1'b0);
`ifndef INPUT_BUFFER_BITREV_EN
        checks++;
        if (snap5[3] !== {28'(-43), 28'(43)}) begin errors++; $display("FAIL beat5_out3 got %h want %h", snap5[3], {28'(-43), 28'(43)}); end
`else
        checks++;
        if (snap0[1] !== {28'(-128), 28'(128)}) begin errors++; $display("FAIL bitrev_b0_out1 got %h want %h", snap0[1], {28'(-128), 28'(128)}); end
        checks++;
        if (snap0[2] !== {28'(-64), 28'(64)}) begin errors++; $display("FAIL bitrev_b0_out2 got %h want %h", snap0[2], {28'(-64), 28'(64)}); end
`endif
        checks++;
        if (snap31[7] !== {28'(-255), 28'(255)}) begin errors++; $display("FAIL b31_out7 got %h want %h", snap31[7], {28'(-255), 28'(255)}); end
    endtask

    task automatic test_gapped();
        send_frame(0, 1'b1);
        collect("gapped", 1, 1'b0);
    endtask

    task automatic test_restart();
        for (int i = 0; i < 100; i++) drive_sample(1000 + i, -i, i == 0);
        send_frame(1, 1'b0);
        collect("restart", 1, 1'b0);
        checks++;
        if (snap5[4] !== {28'd7, 28'd7}) begin errors++; $display("FAIL restart_value got %h want %h", snap5[4], {28'd7, 28'd7}); end
    endtask

    task automatic test_reset_unload();
        int n;
        int seen;
        send_frame(0, 1'b0);
        n = 0;
        while (data_valid !== 1'b1 && n < 600) begin tick(); n++; end
        repeat (10) tick();
        checks++;
        if (data_valid !== 1'b1 || cal_cycles !== 5'd10) begin
            errors++;
            $display("FAIL rst_unload_pre got dv=%b cal=%0d want dv=1 cal=10", data_valid, cal_cycles);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("rst_unload");
        seen = 0;
        repeat (40) begin
            tick();
            if (data_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_unload_abandon data_valid cycles got %0d want 0", seen); end
        send_frame(0, 1'b0);
        collect("post_reset", 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int t1;
        send_frame(0, 1'b0);
        collect("b2b_first", 1, 1'b1);
        t1 = first_dv_cyc;
        send_frame(1, 1'b0);
        collect("b2b_second", 1, 1'b0);
        checks++;
        if (first_dv_cyc - t1 != 288) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want 288 cycles", first_dv_cyc - t1);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_natural();
        test_gapped();
        test_restart();
        test_reset_unload();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish within 1 ms");
        $fatal(1);
    end

endmodule
